// File: rtl/comp_stream_packer_pkg.sv
// Shared types and helpers for the compressor output stream packer.
package comp_stream_packer_pkg;

    // Default widths of the compressor core and the host AXI stream.
    localparam int COMP_DATA_BITS = 64;
    localparam int AXI_DATA_BITS  = 512;

    // Widest tkeep the helper functions accept; callers zero-extend.
    localparam int KEEP_MAX = 256;

    typedef logic [15:0] byte_cnt_t;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } state_t;

    // Number of asserted byte enables.
    function automatic byte_cnt_t keep_count(input logic [KEEP_MAX-1:0] keep);
        byte_cnt_t n;
        n = '0;
        for (int i = 0; i < KEEP_MAX; i++) begin
            n = n + byte_cnt_t'(keep[i]);
        end
        return n;
    endfunction

    // True when keep is of the form 2^k-1 (all enables packed at the low end).
    function automatic logic keep_is_contig(input logic [KEEP_MAX-1:0] keep);
        return (keep & (keep + 1'b1)) == '0;
    endfunction

endpackage

// File: rtl/stream_byte_shifter.sv
// Left barrel shift of an input beat by a byte offset into a window wide
// enough to hold a full output beat plus one input beat of overhang.
module stream_byte_shifter
    import comp_stream_packer_pkg::*;
#(
    parameter int IN_BYTES  = COMP_DATA_BITS / 8,
    parameter int OUT_BYTES = AXI_DATA_BITS / 8,
    parameter int SHIFT_W   = 7
) (
    input  logic [IN_BYTES*8-1:0]             data,
    input  logic [SHIFT_W-1:0]                shift,
    output logic [(OUT_BYTES+IN_BYTES)*8-1:0] window
);

    localparam int WIN_BITS = (OUT_BYTES + IN_BYTES) * 8;

    logic [WIN_BITS-1:0] stage;

    // One log2 stage per shift bit; each stage moves by 2^b bytes.
    always_comb begin
        stage = WIN_BITS'(data);
        for (int b = 0; b < SHIFT_W; b++) begin
            if (shift[b]) begin
                stage = stage << (8 << b);
            end
        end
        window = stage;
    end

endmodule

// File: rtl/comp_stream_packer.sv
// Narrow-to-wide AXI4-Stream packer for the compressor output path.
// COMPACT=1 packs valid bytes densely across output beats and carries the
// overhang into the next beat (or a FLUSH beat on tlast); COMPACT=0 gives
// each input beat its own lane slot. Also tracks per-frame byte totals and
// flags non-contiguous tkeep in dense mode.
module comp_stream_packer
    import comp_stream_packer_pkg::*;
#(
    parameter int IN_BITS  = COMP_DATA_BITS,
    parameter int OUT_BITS = AXI_DATA_BITS,
    parameter bit COMPACT  = 1'b1,
    parameter int CNT_BITS = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [IN_BITS-1:0]    s_tdata,
    input  logic [IN_BITS/8-1:0]  s_tkeep,
    input  logic                  s_tlast,
    input  logic                  s_tvalid,
    output logic                  s_tready,
    output logic [OUT_BITS-1:0]   m_tdata,
    output logic [OUT_BITS/8-1:0] m_tkeep,
    output logic                  m_tlast,
    output logic                  m_tvalid,
    input  logic                  m_tready,
    output logic [CNT_BITS-1:0]   o_frame_bytes,
    output logic                  o_frame_done,
    output logic                  o_err
);

    localparam int IN_BYTES  = IN_BITS / 8;
    localparam int OUT_BYTES = OUT_BITS / 8;
    localparam int WIN_BITS  = OUT_BITS + IN_BITS;
    localparam int FILL_W    = $clog2(OUT_BYTES) + 1;
    localparam int SLOTS     = OUT_BITS / IN_BITS;
    localparam int SLOT_W    = (SLOTS > 1) ? $clog2(SLOTS) : 1;
    localparam logic [FILL_W-1:0] OUT_BYTES_F = FILL_W'(OUT_BYTES);

    if ((IN_BITS % 8) != 0 || (OUT_BITS % IN_BITS) != 0 || OUT_BYTES > KEEP_MAX) begin : g_bad_widths
        $error("comp_stream_packer: IN_BITS must be a multiple of 8 and OUT_BITS a multiple of IN_BITS");
    end

    state_t               state;
    logic [FILL_W-1:0]    fill;
    logic [OUT_BITS-1:0]  acc;
    logic [OUT_BYTES-1:0] acc_keep;
    logic [SLOT_W-1:0]    slot;
    logic [CNT_BITS-1:0]  frame_cnt;

    logic                 out_free;
    logic                 in_fire;
    logic                 out_fire;
    logic [FILL_W-1:0]    k;
    logic [FILL_W-1:0]    sum;
    logic [FILL_W-1:0]    rem;
    logic                 overflow;
    logic                 keep_bad;
    logic [IN_BITS-1:0]   in_masked;
    logic [WIN_BITS-1:0]  shifted;
    logic [WIN_BITS-1:0]  win;
    logic [OUT_BITS-1:0]  carry_word;
    logic [OUT_BYTES-1:0] sum_keep;
    logic [OUT_BYTES-1:0] fill_keep;
    logic [OUT_BITS-1:0]  lane_data;
    logic [OUT_BYTES-1:0] lane_keep;
    logic                 last_slot;
    logic [CNT_BITS:0]    cnt_sum;
    logic [CNT_BITS-1:0]  cnt_next;

    // Low-contiguous byte-enable mask with n bytes set.
    function automatic logic [OUT_BYTES-1:0] lo_mask(input logic [FILL_W-1:0] n);
        logic [OUT_BYTES-1:0] m;
        for (int i = 0; i < OUT_BYTES; i++) begin
            m[i] = (i < int'(n));
        end
        return m;
    endfunction

    assign out_free = !m_tvalid || m_tready;
    assign s_tready = (state == ST_RUN) && out_free;
    assign in_fire  = s_tvalid && s_tready;
    assign out_fire = m_tvalid && m_tready;

    assign k        = FILL_W'(keep_count(KEEP_MAX'(s_tkeep)));
    assign keep_bad = !keep_is_contig(KEEP_MAX'(s_tkeep));
    assign sum      = fill + k;
    assign overflow = (sum >= OUT_BYTES_F);
    assign rem      = sum - OUT_BYTES_F;

    assign sum_keep  = lo_mask(sum);
    assign fill_keep = lo_mask(fill);

    // Keep only the k low bytes of the beat, whatever the tkeep pattern was.
    always_comb begin
        // NOTE: default first so no path leaves in_masked unassigned, which would infer a latch.
        in_masked = '0;
        for (int i = 0; i < IN_BYTES; i++) begin
            if (i < int'(k)) begin
                in_masked[i*8 +: 8] = s_tdata[i*8 +: 8];
            end
        end
    end

    stream_byte_shifter #(
        .IN_BYTES  (IN_BYTES),
        .OUT_BYTES (OUT_BYTES),
        .SHIFT_W   (FILL_W)
    ) u_shifter (
        .data   (in_masked),
        .shift  (fill),
        .window (shifted)
    );

    // Bytes above fill in acc are always zero, so OR merges without masking.
    assign win        = {{IN_BITS{1'b0}}, acc} | shifted;
    // Overhang beyond one output beat never exceeds one input beat.
    assign carry_word = OUT_BITS'(win[WIN_BITS-1 -: IN_BITS]);

    // Lane mode: drop the current beat and its tkeep into the active slot.
    always_comb begin
        lane_data = acc;
        lane_keep = acc_keep;
        lane_data[int'(slot)*IN_BITS +: IN_BITS]   = s_tdata;
        lane_keep[int'(slot)*IN_BYTES +: IN_BYTES] = s_tkeep;
    end

    assign last_slot = (slot == SLOT_W'(SLOTS - 1));

    // Saturating frame byte total including the beat now leaving.
    assign cnt_sum  = {1'b0, frame_cnt} + (CNT_BITS+1)'(keep_count(KEEP_MAX'(m_tkeep)));
    assign cnt_next = cnt_sum[CNT_BITS] ? '1 : cnt_sum[CNT_BITS-1:0];

    // Packing datapath, output register and RUN/FLUSH sequencing.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            // NOTE: the accumulator is reset despite being datapath: a mid-frame reset
            // must not let stale bytes OR into the first beat of the next frame.
            state    <= ST_RUN;
            fill     <= '0;
            slot     <= '0;
            acc      <= '0;
            acc_keep <= '0;
            m_tvalid <= 1'b0;
            m_tlast  <= 1'b0;
            m_tkeep  <= '0;
            m_tdata  <= '0;
            o_err    <= 1'b0;
        end else begin
            // NOTE: non-blocking throughout, so a later load in this block overrides
            // this clear and every decision uses the pre-edge register values.
            if (out_fire) begin
                m_tvalid <= 1'b0;
            end

            if (state == ST_FLUSH) begin
                if (out_free) begin
                    m_tvalid <= 1'b1;
                    m_tdata  <= acc;
                    m_tkeep  <= fill_keep;
                    m_tlast  <= 1'b1;
                    acc      <= '0;
                    fill     <= '0;
                    state    <= ST_RUN;
                end
            end else if (in_fire) begin
                if (COMPACT) begin
                    if (keep_bad) begin
                        o_err <= 1'b1;
                    end
                    if (overflow) begin
                        m_tvalid <= 1'b1;
                        m_tdata  <= win[OUT_BITS-1:0];
                        m_tkeep  <= '1;
                        m_tlast  <= s_tlast && (rem == '0);
                        acc      <= carry_word;
                        fill     <= rem;
                        if (s_tlast && (rem != '0)) begin
                            state <= ST_FLUSH;
                        end
                    end else if (s_tlast) begin
                        m_tvalid <= 1'b1;
                        m_tdata  <= win[OUT_BITS-1:0];
                        m_tkeep  <= sum_keep;
                        m_tlast  <= 1'b1;
                        acc      <= '0;
                        fill     <= '0;
                    end else begin
                        acc  <= win[OUT_BITS-1:0];
                        fill <= sum;
                    end
                end else begin
                    if (last_slot || s_tlast) begin
                        m_tvalid <= 1'b1;
                        m_tdata  <= lane_data;
                        m_tkeep  <= lane_keep;
                        m_tlast  <= s_tlast;
                        acc      <= '0;
                        acc_keep <= '0;
                        slot     <= '0;
                    end else begin
                        acc      <= lane_data;
                        acc_keep <= lane_keep;
                        slot     <= slot + 1'b1;
                    end
                end
            end
        end
    end

    // Per-frame byte total, reported and cleared when the tlast beat leaves.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            frame_cnt     <= '0;
            o_frame_bytes <= '0;
            o_frame_done  <= 1'b0;
        end else begin
            o_frame_done <= 1'b0;
            if (out_fire) begin
                if (m_tlast) begin
                    o_frame_bytes <= cnt_next;
                    o_frame_done  <= 1'b1;
                    frame_cnt     <= '0;
                end else begin
                    frame_cnt <= cnt_next;
                end
            end
        end
    end

endmodule

// File: tb/tb_comp_stream_packer.sv
// Directed bench for comp_stream_packer: dense (COMPACT=1) and lane-slot
// (COMPACT=0) instances, 64-bit in, 512-bit out.
`timescale 1ns/1ps
module tb_comp_stream_packer;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // Dense-mode instance.
    logic [63:0]  s_tdata;
    logic [7:0]   s_tkeep;
    logic         s_tlast, s_tvalid, s_tready;
    logic [511:0] m_tdata;
    logic [63:0]  m_tkeep;
    logic         m_tlast, m_tvalid, m_tready;
    logic [31:0]  o_frame_bytes;
    logic         o_frame_done, o_err;

    // Lane-mode instance.
    logic [63:0]  l_s_tdata;
    logic [7:0]   l_s_tkeep;
    logic         l_s_tlast, l_s_tvalid, l_s_tready;
    logic [511:0] l_m_tdata;
    logic [63:0]  l_m_tkeep;
    logic         l_m_tlast, l_m_tvalid, l_m_tready;
    logic [31:0]  l_o_frame_bytes;
    logic         l_o_frame_done, l_o_err;

    comp_stream_packer #(.IN_BITS(64), .OUT_BITS(512), .COMPACT(1'b1), .CNT_BITS(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .s_tdata(s_tdata), .s_tkeep(s_tkeep), .s_tlast(s_tlast), .s_tvalid(s_tvalid), .s_tready(s_tready),
        .m_tdata(m_tdata), .m_tkeep(m_tkeep), .m_tlast(m_tlast), .m_tvalid(m_tvalid), .m_tready(m_tready),
        .o_frame_bytes(o_frame_bytes), .o_frame_done(o_frame_done), .o_err(o_err)
    );

    comp_stream_packer #(.IN_BITS(64), .OUT_BITS(512), .COMPACT(1'b0), .CNT_BITS(32)) dut_lane (
        .clk(clk), .rst_n(rst_n),
        .s_tdata(l_s_tdata), .s_tkeep(l_s_tkeep), .s_tlast(l_s_tlast), .s_tvalid(l_s_tvalid), .s_tready(l_s_tready),
        .m_tdata(l_m_tdata), .m_tkeep(l_m_tkeep), .m_tlast(l_m_tlast), .m_tvalid(l_m_tvalid), .m_tready(l_m_tready),
        .o_frame_bytes(l_o_frame_bytes), .o_frame_done(l_o_frame_done), .o_err(l_o_err)
    );

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0]  exp_q[$];
    logic [7:0]  got_q[$];
    logic [63:0] beat_keep_q[$];
    logic        beat_last_q[$];
    logic [31:0] done_q[$];

    bit hold_ready = 1'b1;
    bit rand_ready = 1'b0;

    // m_tready source: fixed level or 50% random, changed just after each edge.
    always @(posedge clk) begin
        #1;
        m_tready = rand_ready ? 1'($urandom_range(0, 1)) : hold_ready;
    end

    // Output monitor, sampled on the falling edge: logs handshaken beats and
    // frame reports, and checks that a stalled beat is held unchanged.
    logic         stall_prev = 1'b0;
    logic [511:0] prev_data;
    logic [63:0]  prev_keep;
    logic         prev_last;
    always @(negedge clk) begin
        if (!rst_n) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                n_checks++;
                if (m_tvalid !== 1'b1 || m_tdata !== prev_data || m_tkeep !== prev_keep || m_tlast !== prev_last) begin
                    n_errors++;
                    $display("FAIL stall_hold: got valid=%b keep=%h last=%b, want valid=1 keep=%h last=%b (data held)",
                             m_tvalid, m_tkeep, m_tlast, prev_keep, prev_last);
                end
            end
            if (m_tvalid && m_tready) begin
                for (int i = 0; i < 64; i++) begin
                    if (m_tkeep[i]) got_q.push_back(m_tdata[i*8 +: 8]);
                end
                beat_keep_q.push_back(m_tkeep);
                beat_last_q.push_back(m_tlast);
            end
            if (o_frame_done) done_q.push_back(o_frame_bytes);
            stall_prev = m_tvalid && !m_tready;
            prev_data  = m_tdata;
            prev_keep  = m_tkeep;
            prev_last  = m_tlast;
        end
    end

    function automatic int byte_mismatches();
        int n;
        n = 0;
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            if (got_q[i] !== exp_q[i]) n++;
        end
        return n;
    endfunction

    task automatic clear_logs();
        exp_q.delete();
        got_q.delete();
        beat_keep_q.delete();
        beat_last_q.delete();
        done_q.delete();
    endtask

    task automatic set_ready(input bit r);
        hold_ready = r;
        rand_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    // Present one beat to the dense instance; returns 1ns after the accepting edge.
    task automatic send_beat(input logic [63:0] d, input logic [7:0] k, input logic l);
        int guard;
        guard    = 0;
        s_tdata  = d;
        s_tkeep  = k;
        s_tlast  = l;
        s_tvalid = 1'b1;
        @(negedge clk);
        while (!s_tready && guard < 500) begin
            @(negedge clk);
            guard++;
        end
        if (!s_tready) begin
            n_checks++;
            n_errors++;
            $display("FAIL send_timeout: s_tready got=0 want=1 within 500 cycles");
        end
        @(posedge clk);
        #1;
        s_tvalid = 1'b0;
    endtask

    task automatic wait_done(input int n, input string name);
        int guard;
        guard = 0;
        while (done_q.size() < n && guard < 2000) begin
            @(negedge clk);
            guard++;
        end
        if (done_q.size() < n) begin
            n_checks++;
            n_errors++;
            $display("FAIL %s.frames_timeout: got=%0d want=%0d", name, done_q.size(), n);
        end
    endtask

    task automatic test_reset();
        n_checks++;
        if (m_tvalid !== 1'b0 || m_tlast !== 1'b0 || m_tkeep !== '0 || m_tdata !== '0) begin
            n_errors++;
            $display("FAIL reset.m_outputs: got valid=%b last=%b keep=%h want all 0", m_tvalid, m_tlast, m_tkeep);
        end
        n_checks++;
        if (o_frame_bytes !== '0 || o_frame_done !== 1'b0 || o_err !== 1'b0) begin
            n_errors++;
            $display("FAIL reset.status: got bytes=%0d done=%b err=%b want 0 0 0", o_frame_bytes, o_frame_done, o_err);
        end
        n_checks++;
        if (l_m_tvalid !== 1'b0 || l_m_tkeep !== '0 || l_o_err !== 1'b0) begin
            n_errors++;
            $display("FAIL reset.lane: got valid=%b keep=%h err=%b want 0", l_m_tvalid, l_m_tkeep, l_o_err);
        end
        n_checks++;
        if (s_tready !== 1'b1) begin
            n_errors++;
            $display("FAIL reset.s_tready: got=%b want=1", s_tready);
        end
    endtask

    task automatic test_full_frame();
        logic [63:0] d;
        set_ready(1'b1);
        clear_logs();
        for (int b = 0; b < 8; b++) begin
            for (int j = 0; j < 8; j++) begin
                d[j*8 +: 8] = 8'(b*8 + j);
                exp_q.push_back(8'(b*8 + j));
            end
            send_beat(d, 8'hFF, b == 7);
        end
        wait_done(1, "full_frame");
        n_checks++;
        if (beat_keep_q.size() != 1) begin
            n_errors++;
            $display("FAIL full_frame.beats: got=%0d want=1", beat_keep_q.size());
        end else begin
            n_checks++;
            if (beat_keep_q[0] !== 64'hFFFF_FFFF_FFFF_FFFF || beat_last_q[0] !== 1'b1) begin
                n_errors++;
                $display("FAIL full_frame.keep_last: got keep=%h last=%b want all-1 last=1", beat_keep_q[0], beat_last_q[0]);
            end
        end
        n_checks++;
        if (got_q.size() != 64 || byte_mismatches() != 0) begin
            n_errors++;
            $display("FAIL full_frame.bytes: got %0d bytes %0d wrong, want 64 bytes 0 wrong", got_q.size(), byte_mismatches());
        end
        n_checks++;
        if (done_q.size() > 0 && done_q[0] !== 32'd64) begin
            n_errors++;
            $display("FAIL full_frame.frame_bytes: got=%0d want=64", done_q[0]);
        end
    endtask

    task automatic test_flush();
        logic [63:0] d;
        set_ready(1'b1);
        clear_logs();
        for (int b = 0; b < 13; b++) begin
            d = 64'hEEEE_EEEE_EEEE_EEEE;
            for (int j = 0; j < 5; j++) begin
                d[j*8 +: 8] = 8'(b*5 + j);
                exp_q.push_back(8'(b*5 + j));
            end
            send_beat(d, 8'h1F, b == 12);
        end
        // Right after the 65th byte: full beat out, one byte carried, FLUSH pending.
        n_checks++;
        if (s_tready !== 1'b0) begin
            n_errors++;
            $display("FAIL flush.s_tready: got=%b want=0", s_tready);
        end
        wait_done(1, "flush");
        n_checks++;
        if (beat_keep_q.size() != 2) begin
            n_errors++;
            $display("FAIL flush.beats: got=%0d want=2", beat_keep_q.size());
        end else begin
            n_checks++;
            if (beat_keep_q[0] !== 64'hFFFF_FFFF_FFFF_FFFF || beat_last_q[0] !== 1'b0) begin
                n_errors++;
                $display("FAIL flush.beat0: got keep=%h last=%b want all-1 last=0", beat_keep_q[0], beat_last_q[0]);
            end
            n_checks++;
            if (beat_keep_q[1] !== 64'h1 || beat_last_q[1] !== 1'b1) begin
                n_errors++;
                $display("FAIL flush.beat1: got keep=%h last=%b want 1 last=1", beat_keep_q[1], beat_last_q[1]);
            end
        end
        n_checks++;
        if (got_q.size() != 65 || byte_mismatches() != 0) begin
            n_errors++;
            $display("FAIL flush.bytes: got %0d bytes %0d wrong, want 65 bytes 0 wrong", got_q.size(), byte_mismatches());
        end
        n_checks++;
        if (done_q.size() > 0 && done_q[0] !== 32'd65) begin
            n_errors++;
            $display("FAIL flush.frame_bytes: got=%0d want=65", done_q[0]);
        end
    endtask

    task automatic test_empty_tlast();
        set_ready(1'b1);
        repeat (5) @(posedge clk);
        #1;
        clear_logs();
        send_beat(64'h1234_5678_9ABC_DEF0, 8'h00, 1'b1);
        wait_done(1, "empty");
        n_checks++;
        if (beat_keep_q.size() != 1 || beat_keep_q[0] !== 64'h0 || beat_last_q[0] !== 1'b1) begin
            n_errors++;
            $display("FAIL empty.beat: got beats=%0d want 1 beat keep=0 last=1", beat_keep_q.size());
        end
        n_checks++;
        if (done_q.size() > 0 && done_q[0] !== 32'd0) begin
            n_errors++;
            $display("FAIL empty.frame_bytes: got=%0d want=0", done_q[0]);
        end
        @(negedge clk);
        n_checks++;
        if (o_frame_done !== 1'b0) begin
            n_errors++;
            $display("FAIL empty.done_pulse: got=%b want=0 one cycle later", o_frame_done);
        end
    endtask

    task automatic test_lane();
        logic [63:0] d [3];
        logic [7:0]  kp [3];
        d[0] = 64'h0000_0000_0A0B_0C0D; kp[0] = 8'h0F;
        d[1] = 64'h1122_3344_5566_7788; kp[1] = 8'hFF;
        d[2] = 64'h0000_0000_0000_9F8E; kp[2] = 8'h03;
        l_m_tready = 1'b0;
        for (int b = 0; b < 3; b++) begin
            n_checks++;
            if (l_s_tready !== 1'b1) begin
                n_errors++;
                $display("FAIL lane.s_tready%0d: got=%b want=1", b, l_s_tready);
            end
            l_s_tdata  = d[b];
            l_s_tkeep  = kp[b];
            l_s_tlast  = (b == 2);
            l_s_tvalid = 1'b1;
            @(posedge clk);
            #1;
        end
        l_s_tvalid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (l_m_tvalid !== 1'b1 || l_m_tlast !== 1'b1 || l_m_tkeep !== 64'h0000_0000_0003_FF0F) begin
            n_errors++;
            $display("FAIL lane.keep: got valid=%b last=%b keep=%h want 1 1 000000000003ff0f", l_m_tvalid, l_m_tlast, l_m_tkeep);
        end
        n_checks++;
        if (l_m_tdata[191:0] !== {d[2], d[1], d[0]} || l_m_tdata[511:192] !== '0) begin
            n_errors++;
            $display("FAIL lane.data: got low=%h want %h%h%h", l_m_tdata[191:0], d[2], d[1], d[0]);
        end
        l_m_tready = 1'b1;
        @(posedge clk);
        #1;
        n_checks++;
        if (l_o_frame_done !== 1'b1 || l_o_frame_bytes !== 32'd14 || l_m_tvalid !== 1'b0) begin
            n_errors++;
            $display("FAIL lane.frame: got done=%b bytes=%0d valid=%b want 1 14 0", l_o_frame_done, l_o_frame_bytes, l_m_tvalid);
        end
        // A gapped tkeep is legal in lane mode and must not raise the error flag.
        l_s_tdata  = 64'h55;
        l_s_tkeep  = 8'h05;
        l_s_tlast  = 1'b1;
        l_s_tvalid = 1'b1;
        @(posedge clk);
        #1;
        l_s_tvalid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (l_o_err !== 1'b0) begin
            n_errors++;
            $display("FAIL lane.err: got=%b want=0", l_o_err);
        end
    endtask

    task automatic test_mid_reset();
        logic [63:0] d;
        set_ready(1'b1);
        clear_logs();
        for (int b = 0; b < 3; b++) send_beat(64'hDEAD_BEEF_CAFE_F00D, 8'hFF, 1'b0);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        n_checks++;
        if (m_tvalid !== 1'b0) begin
            n_errors++;
            $display("FAIL mid_reset.valid: got=%b want=0", m_tvalid);
        end
        repeat (4) @(posedge clk);
        #1;
        n_checks++;
        if (beat_keep_q.size() != 0) begin
            n_errors++;
            $display("FAIL mid_reset.no_output: got beats=%0d want=0", beat_keep_q.size());
        end
        for (int b = 0; b < 8; b++) begin
            for (int j = 0; j < 8; j++) begin
                d[j*8 +: 8] = 8'(100 + b*8 + j);
                exp_q.push_back(8'(100 + b*8 + j));
            end
            send_beat(d, 8'hFF, b == 7);
        end
        wait_done(1, "mid_reset");
        n_checks++;
        if (beat_keep_q.size() != 1 || got_q.size() != 64 || byte_mismatches() != 0) begin
            n_errors++;
            $display("FAIL mid_reset.clean_frame: got beats=%0d bytes=%0d wrong=%0d want 1 64 0",
                     beat_keep_q.size(), got_q.size(), byte_mismatches());
        end
        n_checks++;
        if (done_q.size() > 0 && done_q[0] !== 32'd64) begin
            n_errors++;
            $display("FAIL mid_reset.frame_bytes: got=%0d want=64", done_q[0]);
        end
    endtask

    task automatic test_keep_err();
        set_ready(1'b1);
        clear_logs();
        n_checks++;
        if (o_err !== 1'b0) begin
            n_errors++;
            $display("FAIL keep_err.before: got=%b want=0", o_err);
        end
        // keep=05 has popcount 2: bytes 0 and 1 are packed regardless of the gap.
        send_beat(64'h0000_0000_0033_2211, 8'h05, 1'b0);
        exp_q.push_back(8'h11);
        exp_q.push_back(8'h22);
        n_checks++;
        if (o_err !== 1'b1) begin
            n_errors++;
            $display("FAIL keep_err.set: got=%b want=1", o_err);
        end
        send_beat(64'h0000_0000_0000_4433, 8'h03, 1'b1);
        exp_q.push_back(8'h33);
        exp_q.push_back(8'h44);
        wait_done(1, "keep_err");
        n_checks++;
        if (got_q.size() != 4 || byte_mismatches() != 0 || (beat_keep_q.size() > 0 && beat_keep_q[0] !== 64'hF)) begin
            n_errors++;
            $display("FAIL keep_err.packing: got bytes=%0d wrong=%0d want 4 0 keep=f", got_q.size(), byte_mismatches());
        end
        n_checks++;
        if (o_err !== 1'b1) begin
            n_errors++;
            $display("FAIL keep_err.sticky: got=%b want=1", o_err);
        end
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        n_checks++;
        if (o_err !== 1'b0) begin
            n_errors++;
            $display("FAIL keep_err.cleared: got=%b want=0", o_err);
        end
    endtask

    task automatic test_random_stream();
        logic [31:0] frame_q[$];
        logic [63:0] d;
        int          k;
        int          flen;
        int          bad_keep;
        logic        l;
        set_ready(1'b1);
        clear_logs();
        flen = 0;
        rand_ready = 1'b1;
        for (int i = 0; i < 800; i++) begin
            k = $urandom_range(0, 8);
            d = {$urandom, $urandom};
            l = ($urandom_range(0, 7) == 0) || (i == 799);
            for (int j = 0; j < k; j++) exp_q.push_back(d[j*8 +: 8]);
            flen += k;
            if (l) begin
                frame_q.push_back(32'(flen));
                flen = 0;
            end
            send_beat(d, 8'((1 << k) - 1), l);
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
            end
        end
        rand_ready = 1'b0;
        wait_done(frame_q.size(), "random");
        n_checks++;
        if (got_q.size() != exp_q.size() || byte_mismatches() != 0) begin
            n_errors++;
            $display("FAIL random.bytes: got %0d bytes %0d wrong, want %0d bytes 0 wrong",
                     got_q.size(), byte_mismatches(), exp_q.size());
        end
        n_checks++;
        if (done_q.size() != frame_q.size()) begin
            n_errors++;
            $display("FAIL random.frame_count: got=%0d want=%0d", done_q.size(), frame_q.size());
        end
        for (int f = 0; f < frame_q.size() && f < done_q.size(); f++) begin
            n_checks++;
            if (done_q[f] !== frame_q[f]) begin
                n_errors++;
                $display("FAIL random.frame_bytes[%0d]: got=%0d want=%0d", f, done_q[f], frame_q[f]);
            end
        end
        bad_keep = 0;
        for (int b = 0; b < beat_keep_q.size(); b++) begin
            if (!beat_last_q[b] && beat_keep_q[b] !== 64'hFFFF_FFFF_FFFF_FFFF) bad_keep++;
            if (beat_last_q[b] && (beat_keep_q[b] & (beat_keep_q[b] + 64'd1)) !== 64'd0) bad_keep++;
        end
        n_checks++;
        if (bad_keep != 0) begin
            n_errors++;
            $display("FAIL random.keep_shape: got %0d malformed beats want 0", bad_keep);
        end
    endtask

    initial begin
        s_tdata    = '0;
        s_tkeep    = '0;
        s_tlast    = 1'b0;
        s_tvalid   = 1'b0;
        m_tready   = 1'b1;
        l_s_tdata  = '0;
        l_s_tkeep  = '0;
        l_s_tlast  = 1'b0;
        l_s_tvalid = 1'b0;
        l_m_tready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        rst_n = 1'b1;
        test_full_frame();
        test_flush();
        test_empty_tlast();
        test_lane();
        test_mid_reset();
        test_keep_err();
        test_random_stream();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL global_timeout: simulation still running at 5 ms, want finished");
        $fatal(1, "timeout");
    end

endmodule
